// File: rtl/ap_ctrl_multi.sv
// ap_ctrl_multi: per-channel ap_ctrl_hs start queue, done counter, throttle, latency and sticky error flags; trig/claim in, ap_start out, status out
module ap_ctrl_multi #(
   parameter int NUM_CH     = 4,
   parameter int PEND_DEPTH = 4,
   parameter int DONE_DEPTH = 2,
   parameter int LAT_W      = 16
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic [NUM_CH-1:0]         start_trig,
   input  logic [NUM_CH-1:0]         complete_trig,
   output logic [NUM_CH-1:0]         finish,
   output logic [NUM_CH-1:0]         idle,
   output logic [NUM_CH-1:0]         pend_full,
   output logic [NUM_CH*LAT_W-1:0]   lat,
   output logic [NUM_CH-1:0]         trig_drop,
   output logic [NUM_CH-1:0]         claim_err,
   input  logic                      err_clr,
   output logic [NUM_CH-1:0]         ap_start,
   input  logic [NUM_CH-1:0]         ap_ready,
   input  logic [NUM_CH-1:0]         ap_done,
   input  logic [NUM_CH-1:0]         ap_idle
);
   localparam int PW = $clog2(PEND_DEPTH + 1);
   localparam int DW = $clog2(DONE_DEPTH + 1);
   typedef enum logic [1:0] {IDLE, START, BUSY} state_t;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t            state;
      logic [PW-1:0]     pend_cnt;
      logic [DW-1:0]     done_cnt;
      logic [LAT_W-1:0]  lat_cnt, lat_q, lat_inc;
      logic              drop_q, cerr_q;
      logic              run, full, dispatch, accept, done_evt, claim, no_claim, done_inc;
      assign run      = state != IDLE;
      assign full     = pend_cnt == PW'(PEND_DEPTH);
      assign dispatch = state == IDLE && pend_cnt != '0 && done_cnt != DW'(DONE_DEPTH);
      assign accept   = start_trig[i] && (!full || dispatch);
      assign done_evt = run && ap_done[i];
      assign claim    = complete_trig[i] && done_cnt != '0;
      assign no_claim = complete_trig[i] && done_cnt == '0;
      assign done_inc = done_evt && (done_cnt != DW'(DONE_DEPTH) || claim);
      assign lat_inc  = &lat_cnt ? lat_cnt : lat_cnt + LAT_W'(1);
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            state    <= IDLE;
            pend_cnt <= '0;
            done_cnt <= '0;
            lat_cnt  <= '0;
            lat_q    <= '0;
            drop_q   <= 1'b0;
            cerr_q   <= 1'b0;
         end else begin
            state    <= dispatch ? START :
                        state == START && ap_ready[i] ? (ap_done[i] ? IDLE : BUSY) :
                        state == BUSY && ap_done[i] ? IDLE : state;
            pend_cnt <= pend_cnt + PW'(accept) - PW'(dispatch);
            done_cnt <= done_cnt + DW'(done_inc) - DW'(claim);
            lat_cnt  <= dispatch ? '0 : run ? lat_inc : lat_cnt;
            lat_q    <= done_evt ? lat_inc : lat_q;
            drop_q   <= (start_trig[i] && !accept) || (drop_q && !err_clr);
            cerr_q   <= no_claim || (cerr_q && !err_clr);
         end
      end
      assign ap_start[i]              = state == START;
      assign finish[i]                = done_cnt != '0;
      assign pend_full[i]             = full;
      assign idle[i]                  = ap_idle[i] && state == IDLE && pend_cnt == '0 && done_cnt == '0;
      assign lat[i*LAT_W +: LAT_W]    = lat_q;
      assign trig_drop[i]             = drop_q;
      assign claim_err[i]             = cerr_q;
   end
endmodule

// File: tb/tb_ap_ctrl_multi.sv
// tb_ap_ctrl_multi: directed bench with core model and latency scoreboard for ap_ctrl_multi
module tb_ap_ctrl_multi;
   localparam int N  = 4;
   localparam int LW = 16;
   logic clk = 1'b0, rst_n = 1'b0, err_clr = 1'b0;
   logic [N-1:0] start_trig = '0, complete_trig = '0, ap_ready = '0, task_done = '0, spur = '0, ap_idle = '1;
   logic [N-1:0] ap_done, finish, idle, pend_full, trig_drop, claim_err, ap_start, done_q, act = '0;
   logic [N*LW-1:0] lat;
   int errors = 0, checks = 0;
   int cfg_r[N][$], cfg_d[N][$], exp_lat[N][$];
   int mr[N], md[N], cnt[N];
   assign ap_done = task_done | spur;
   always #5 clk = ~clk;
   ap_ctrl_multi #(.NUM_CH(N), .PEND_DEPTH(4), .DONE_DEPTH(2), .LAT_W(LW)) dut (
      .ap_clk(clk), .ap_rst_n(rst_n), .start_trig(start_trig), .complete_trig(complete_trig),
      .finish(finish), .idle(idle), .pend_full(pend_full), .lat(lat), .trig_drop(trig_drop),
      .claim_err(claim_err), .err_clr(err_clr), .ap_start(ap_start), .ap_ready(ap_ready),
      .ap_done(ap_done), .ap_idle(ap_idle)
   );
   task automatic chk(input string nm, input int a, input int e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
      end
   endtask
   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask
   task automatic push(input int ch, input int r, input int d);
      cfg_r[ch].push_back(r);
      cfg_d[ch].push_back(d);
      exp_lat[ch].push_back(r + d + 1);
   endtask
   task automatic trig(input logic [N-1:0] m);
      start_trig = m;
      cyc();
      start_trig = '0;
   endtask
   task automatic claim(input logic [N-1:0] m);
      complete_trig = m;
      cyc();
      complete_trig = '0;
   endtask
   task automatic wait_fin(input int ch);
      int k = 0;
      while (!finish[ch] && k < 300) begin
         cyc();
         k++;
      end
      chk("finish_wait", int'(finish[ch]), 1);
   endtask
   // core model: ap_ready r cycles after ap_start is seen, ap_done d cycles after that
   initial forever begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
         if (!rst_n) begin
            act[g] = 1'b0;
            ap_ready[g] = 1'b0;
            task_done[g] = 1'b0;
         end else begin
            if (!act[g]) begin
               ap_ready[g] = 1'b0;
               task_done[g] = 1'b0;
               if (ap_start[g] && cfg_r[g].size() > 0) begin
                  mr[g] = cfg_r[g].pop_front();
                  md[g] = cfg_d[g].pop_front();
                  act[g] = 1'b1;
                  cnt[g] = 0;
               end
            end
            if (act[g]) begin
               ap_ready[g] = cnt[g] == mr[g];
               task_done[g] = cnt[g] == mr[g] + md[g];
               if (cnt[g] == mr[g] + md[g]) act[g] = 1'b0;
               cnt[g]++;
            end
         end
         ap_idle[g] = !act[g];
      end
   end
   always @(posedge clk or negedge rst_n)
      if (!rst_n) done_q <= '0;
      else done_q <= task_done;
   // scoreboard monitor: each sampled task completion pops one expected latency
   initial forever begin
      @(negedge clk);
      for (int g = 0; g < N; g++)
         if (done_q[g]) begin
            chk("lat", int'(lat[g*LW +: LW]), exp_lat[g].size() > 0 ? exp_lat[g].pop_front() : -1);
            chk("finish_after_done", int'(finish[g]), 1);
         end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      cyc(3);
      chk("rst_ap_start", int'(ap_start), 0);
      chk("rst_finish", int'(finish), 0);
      chk("rst_pend_full", int'(pend_full), 0);
      chk("rst_trig_drop", int'(trig_drop), 0);
      chk("rst_claim_err", int'(claim_err), 0);
      chk("rst_lat", int'(lat), 0);
      chk("rst_idle", int'(idle), 4'hF);
      rst_n = 1'b1;
      cyc(2);
      // single task on ch0
      push(0, 2, 3);
      trig(4'b0001);
      chk("t1_start_c1", int'(ap_start[0]), 0);
      cyc();
      chk("t1_start_c2", int'(ap_start[0]), 1);
      cyc(2);
      chk("t1_start_c4", int'(ap_start[0]), 1);
      cyc();
      chk("t1_start_c5", int'(ap_start[0]), 0);
      cyc(2);
      chk("t1_finish_c7", int'(finish[0]), 0);
      cyc();
      chk("t1_finish_c8", int'(finish[0]), 1);
      chk("t1_lat", int'(lat[0 +: LW]), 6);
      claim(4'b0001);
      chk("t1_finish_clr", int'(finish[0]), 0);
      chk("t1_idle", int'(idle[0]), 1);
      // ap_done while idle is ignored
      spur[1] = 1'b1;
      cyc();
      spur[1] = 1'b0;
      cyc();
      chk("idle_done_ignored", int'(finish[1]), 0);
      // queue overflow on ch1
      push(1, 6, 0);
      repeat (4) push(1, 1, 1);
      start_trig = 4'b0010;
      cyc(6);
      start_trig = '0;
      chk("ovf_pend_full", int'(pend_full[1]), 1);
      chk("ovf_trig_drop", int'(trig_drop[1]), 1);
      repeat (5) begin
         wait_fin(1);
         claim(4'b0010);
      end
      cyc(3);
      chk("ovf_ran5", exp_lat[1].size(), 0);
      chk("ovf_pend_empty", int'(pend_full[1]), 0);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("ovf_drop_clr", int'(trig_drop[1]), 0);
      chk("ovf_no_claim_err", int'(claim_err[1]), 0);
      // throttle and combined ready+done on ch2
      repeat (3) push(2, 0, 0);
      start_trig = 4'b0100;
      cyc(2);
      chk("thr_start_c2", int'(ap_start[2]), 1);
      cyc();
      start_trig = '0;
      chk("thr_direct_idle", int'(ap_start[2]), 0);
      chk("thr_done1", int'(finish[2]), 1);
      cyc();
      chk("thr_start_c4", int'(ap_start[2]), 1);
      cyc(4);
      chk("thr_withheld", int'(ap_start[2]), 0);
      claim(4'b0100);
      chk("thr_c9", int'(ap_start[2]), 0);
      cyc();
      chk("thr_c10", int'(ap_start[2]), 1);
      cyc(2);
      claim(4'b0100);
      claim(4'b0100);
      chk("thr_drained", int'(finish[2]), 0);
      chk("thr_no_err", int'(claim_err[2]), 0);
      // simultaneous claim and done on ch3
      push(3, 0, 0);
      trig(4'b1000);
      cyc(2);
      chk("sim_pre", int'(finish[3]), 1);
      push(3, 0, 3);
      trig(4'b1000);
      cyc(4);
      claim(4'b1000);
      chk("sim_hold", int'(finish[3]), 1);
      chk("sim_no_err", int'(claim_err[3]), 0);
      claim(4'b1000);
      chk("sim_empty", int'(finish[3]), 0);
      claim(4'b1000);
      chk("sim_claim_err", int'(claim_err[3]), 1);
      chk("sim_still_empty", int'(finish[3]), 0);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("sim_err_clr", int'(claim_err[3]), 0);
      complete_trig = 4'b1000;
      err_clr = 1'b1;
      cyc();
      complete_trig = '0;
      err_clr = 1'b0;
      chk("err_clr_coincident", int'(claim_err[3]), 1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("err_clr_after", int'(claim_err[3]), 0);
      // all channels interleaved
      push(0, 1, 2);
      push(1, 3, 1);
      push(2, 0, 5);
      push(3, 2, 0);
      trig(4'b1111);
      cyc(15);
      chk("multi_finish", int'(finish), 4'hF);
      claim(4'b1111);
      chk("multi_claimed", int'(finish), 0);
      chk("multi_no_err", int'(claim_err), 0);
      // reset mid-task
      push(0, 0, 20);
      push(1, 20, 0);
      trig(4'b0011);
      push(0, 1, 1);
      trig(4'b0001);
      cyc(3);
      chk("pre_reset_start", int'(ap_start), 4'b0010);
      #2 rst_n = 1'b0;
      #1 chk("async_start_drop", int'(ap_start), 0);
      for (int g = 0; g < N; g++) begin
         cfg_r[g].delete();
         cfg_d[g].delete();
         exp_lat[g].delete();
      end
      cyc(2);
      chk("mid_rst_finish", int'(finish), 0);
      chk("mid_rst_pend_full", int'(pend_full), 0);
      chk("mid_rst_lat", int'(lat), 0);
      chk("mid_rst_errs", int'(trig_drop | claim_err), 0);
      chk("mid_rst_idle", int'(idle), 4'hF);
      rst_n = 1'b1;
      cyc(10);
      chk("post_rst_no_task", int'(ap_start), 0);
      chk("post_rst_idle", int'(idle), 4'hF);
      push(2, 0, 0);
      trig(4'b0100);
      wait_fin(2);
      claim(4'b0100);
      cyc(2);
      for (int g = 0; g < N; g++) chk("scoreboard_empty", exp_lat[g].size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ap_ctrl_multi.md
# ap_ctrl_multi

Parametrised multi-channel controller for HLS `ap_ctrl_hs` kernels, sitting between the tool-IP control logic and up to `NUM_CH` HLS cores.
- Queues start requests per channel and holds `ap_start` per the HLS handshake.
- Counts completed-but-unclaimed tasks and throttles new starts against that count.
- Measures per-task latency and flags protocol misuse.
- Fully registered per-channel FSMs replace the earlier single-channel combinational-latch controller.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent HLS cores controlled.
- `PEND_DEPTH`, 4: maximum queued start requests per channel (≥1).
- `DONE_DEPTH`, 2: maximum completed-unclaimed tasks per channel (≥1).
- `LAT_W`, 16: width of per-channel latency counter.

Ports:
- `ap_clk`  in  1  clock; all logic on rising edge.
- `ap_rst_n`  in  1  reset, asynchronous, active-low.
- `start_trig`  in  NUM_CH  per-channel start request, one request per high cycle.
- `complete_trig`  in  NUM_CH  per-channel claim of one finished task.
- `finish`  out  NUM_CH  channel has ≥1 unclaimed finished task.
- `idle`  out  NUM_CH  channel fully quiescent.
- `pend_full`  out  NUM_CH  pending queue at `PEND_DEPTH`.
- `lat`  out  NUM_CH*LAT_W  latency of last completed task, channel i at `[i*LAT_W +: LAT_W]`.
- `trig_drop`  out  NUM_CH  sticky: a `start_trig` was dropped because the queue was full.
- `claim_err`  out  NUM_CH  sticky: `complete_trig` arrived with nothing to claim.
- `err_clr`  in  1  clears all sticky error bits.
- `ap_start`  out  NUM_CH  to cores.
- `ap_ready`, `ap_done`, `ap_idle`  in  NUM_CH  from cores.

## Operation
Per channel i, all state is independent.
- **pend_cnt** (0..PEND_DEPTH):
  - +1 on `start_trig` when not full; if full, the request is dropped and `trig_drop` is set.
  - −1 on dispatch.
  - Simultaneous trigger and dispatch: count unchanged, and the trigger is accepted even when full.
- **done_cnt** (0..DONE_DEPTH):
  - +1 on `ap_done` while in START or BUSY.
  - −1 on `complete_trig` when >0; when =0, `claim_err` is set and the count is unchanged.
  - Simultaneous done and claim with done_cnt>0: unchanged.
  - Simultaneous done and claim with done_cnt=0: net count 1 and `claim_err` is set, because the claim is evaluated against the pre-edge count.
- **FSM** states IDLE, START, BUSY:
  - IDLE→START when pend_cnt>0 and done_cnt + 1 ≤ DONE_DEPTH (throttle counts the pre-edge done_cnt). This transition is the dispatch: pend_cnt decrements and the latency counter is cleared to 0.
  - START→IDLE on `ap_ready & ap_done`.
  - START→BUSY on `ap_ready & ~ap_done`.
  - BUSY→IDLE on `ap_done`.
  - `ap_done` in IDLE is ignored.
- `ap_start[i]` = (state==START), driven directly from the state register.
- **Latency counter**:
  - Increments each cycle in START/BUSY and saturates at all-ones.
  - On the `ap_done` edge, `lat` captures counter+1, saturated at all-ones.
- `finish[i]` = done_cnt>0.
- `pend_full[i]` = pend_cnt==PEND_DEPTH.
- `idle[i]` = `ap_idle[i]` & state==IDLE & pend_cnt==0 & done_cnt==0.
- Errors: `err_clr` clears the sticky bits; if an error event and `err_clr` occur in the same cycle, the bit stays set.

## Timing
- Reset (async assert, sync release) gives:
  - state=IDLE, counts=0, `lat`=0.
  - `ap_start`=0, `finish`=0, `pend_full`=0, `trig_drop`=0, `claim_err`=0.
  - `idle` follows `ap_idle`.
- Reset mid-task: `ap_start` drops immediately and queued/unclaimed tasks are discarded.
- Trigger latency: `start_trig` high in cycle 0 gives pend_cnt=1 in cycle 1 and `ap_start`=1 in cycle 2.
- `ap_start` stays high until the edge sampling `ap_ready`=1, then is low the next cycle.
- Back-to-back: if pend_cnt>0 when returning to IDLE, `ap_start` re-asserts one cycle after the IDLE cycle (minimum one low cycle between tasks).
- `finish` rises the cycle after `ap_done` is sampled and falls the cycle after the claiming `complete_trig`.
- `lat` = number of cycles `ap_start` was high plus BUSY cycles, counted up to and including the `ap_done` cycle.

## Test plan
- Single task, ch0:
  - Stimulus: trig at cycle 0; core raises `ap_ready` at cycle 4 and `ap_done` at cycle 7.
  - Required: `ap_start` high in cycles 2–4, `finish` high from cycle 8, `lat`=6. After `complete_trig`, `idle`=1.
- Queue overflow, PEND_DEPTH=4:
  - Stimulus: 6 trigs while the core is stalled with `ap_ready`=0.
  - Required: `pend_full`=1, `trig_drop`=1, exactly 5 tasks eventually run.
- Throttle, DONE_DEPTH=2:
  - Stimulus: 3 queued tasks, no claims.
  - Required: two tasks complete and the third `ap_start` is withheld until one `complete_trig`, then it asserts 2 cycles later.
- Combined ready and done:
  - Stimulus: `ap_ready` & `ap_done` in the same cycle.
  - Required: START→IDLE directly, done_cnt=1.
- Simultaneous events:
  - Stimulus: `complete_trig` coincident with `ap_done` (done_cnt=1).
  - Required: done_cnt stays 1, no `claim_err`.
  - Stimulus: `complete_trig` at done_cnt=0.
  - Required: `claim_err`=1; cleared by `err_clr`.
- Channel independence and reset:
  - Stimulus: interleave all 4 channels, then assert `ap_rst_n`=0 mid-BUSY.
  - Required: `ap_start`=0 asynchronously, all outputs at reset values, no task issued after release until a new trig.
